// File: rtl/pipe_stage_buf_if.sv
// Ready/valid handshake bundle around a pipe_stage_buf.
// Signal suffixes are named from the buffer's point of view.
interface pipe_stage_buf_if #(
    parameter int DataWidth = 96,
    parameter int Depth     = 2
);
    localparam int CountWidth = $clog2(Depth + 1);

    logic                  flush_i;
    logic                  valid_i;
    logic [DataWidth-1:0]  data_i;
    logic                  ready_o;
    logic                  valid_o;
    logic [DataWidth-1:0]  data_o;
    logic                  ready_i;
    logic [CountWidth-1:0] count_o;

    modport master (
        output flush_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, count_o
    );

    modport slave (
        input  flush_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, count_o
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Parametrised ready/valid pipeline stage buffer: a circular FIFO with optional
// fall-through when empty, synchronous flush and exported occupancy.
module pipe_stage_buf #(
    parameter int DataWidth        = 96,
    parameter int Depth            = 2,
    parameter bit FallThrough      = 1'b0,
    parameter bit ClearDataOnReset = 1'b0
) (
    input logic             clk_i,
    input logic             reset_ni,
    pipe_stage_buf_if.slave bus
);
    localparam int PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CountWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    logic [DataWidth-1:0]  mem_q [Depth];
    logic [PtrWidth-1:0]   rd_q, rd_d;
    logic [PtrWidth-1:0]   wr_q, wr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  empty, bypass, push, pop, direct, write, read;

    assign empty  = (count_q == '0);
    assign bypass = FallThrough & empty;

    assign bus.ready_o = (count_q < FullCount) & ~bus.flush_i & reset_ni;
    assign bus.valid_o = reset_ni & ~bus.flush_i & (empty ? (bypass & bus.valid_i) : 1'b1);
    assign bus.data_o  = bypass ? bus.data_i : mem_q[rd_q];
    assign bus.count_o = count_q;

    assign push = bus.valid_i & bus.ready_o;
    assign pop  = bus.valid_o & bus.ready_i;

    // An empty fall-through buffer hands the item straight downstream without storing it.
    assign direct = bypass & push & bus.ready_i;
    assign write  = push & ~direct;
    assign read   = pop & ~empty;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (bus.flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (write) begin
                wr_d = (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
            end
            if (read) begin
                rd_d = (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
            end
            if (write && !read) begin
                count_d = count_q + 1'b1;
            end else if (read && !write) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Payload storage only needs a reset when the integrator wants deterministic data_o.
    generate
        if (ClearDataOnReset) begin : gClearMem
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    for (int i = 0; i < Depth; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (write) begin
                    mem_q[wr_q] <= bus.data_i;
                end
            end
        end else begin : gKeepMem
            always_ff @(posedge clk_i) begin
                if (write) begin
                    mem_q[wr_q] <= bus.data_i;
                end
            end
        end
    endgenerate

    assert property (@(posedge clk_i) disable iff (!reset_ni) !(push && count_q == FullCount))
        else $error("push into full buffer");
    assert property (@(posedge clk_i) disable iff (!reset_ni) !(read && empty))
        else $error("pop from empty buffer");
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives four buffer configurations with shared stimulus; each has its own queue
// reference model feeding a scoreboard that an independent monitor drains.
module tb_pipe_stage_buf;
    localparam int DataWidth = 16;
    localparam int NumInst   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 vin;
    logic                 rin;
    logic [DataWidth-1:0] din;
    int                   nChecks = 0;
    int                   nPass   = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Instance 0: Depth 2 registered; 1: Depth 3 registered; 2: Depth 2 fall-through;
    // 3: Depth 1 registered with data cleared on reset.
    for (genvar g = 0; g < NumInst; g++) begin : gInst
        localparam int D   = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 2 : 1;
        localparam bit Ft  = (g == 2);
        localparam bit Cdr = (g == 3);

        pipe_stage_buf_if #(.DataWidth(DataWidth), .Depth(D)) bus ();

        assign bus.flush_i = flush;
        assign bus.valid_i = vin;
        assign bus.data_i  = din;
        assign bus.ready_i = rin;

        pipe_stage_buf #(
            .DataWidth(DataWidth), .Depth(D), .FallThrough(Ft), .ClearDataOnReset(Cdr)
        ) dut (
            .clk_i(clk), .reset_ni(rst_n), .bus(bus)
        );

        logic [DataWidth-1:0] sb [$];
        logic                 expReady;
        logic                 expValid;

        // Feeder: predicts handshake signals from the queue contents and records accepted items.
        always @(negedge clk) begin
            if (!rst_n) begin
                sb.delete();
                checkOutput($sformatf("inst%0d reset valid_o", g), 32'(bus.valid_o), 32'd0);
                checkOutput($sformatf("inst%0d reset ready_o", g), 32'(bus.ready_o), 32'd0);
                checkOutput($sformatf("inst%0d reset count_o", g), 32'(bus.count_o), 32'd0);
                if (Cdr) checkOutput($sformatf("inst%0d reset data_o", g), 32'(bus.data_o), 32'd0);
            end else begin
                expReady = (sb.size() < D) && !flush;
                expValid = !flush && ((sb.size() > 0) || (Ft && vin));
                checkOutput($sformatf("inst%0d count_o", g), 32'(bus.count_o), 32'(sb.size()));
                checkOutput($sformatf("inst%0d ready_o", g), 32'(bus.ready_o), 32'(expReady));
                checkOutput($sformatf("inst%0d valid_o", g), 32'(bus.valid_o), 32'(expValid));
                if (vin && expReady) sb.push_back(din);
                if (flush) sb.delete();
            end
        end

        // Monitor: whenever the DUT completes an output handshake, the head of the scoreboard must match.
        always @(negedge clk) begin
            #1;
            if (rst_n && bus.valid_o && rin) begin
                if (sb.size() == 0) begin
                    checkOutput($sformatf("inst%0d unexpected pop", g), 32'd1, 32'd0);
                end else begin
                    checkOutput($sformatf("inst%0d data_o", g), 32'(bus.data_o), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [DataWidth-1:0] d,
                                 input logic r, input logic f);
        vin   = v;
        din   = d;
        rin   = r;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] wrapReady;
        wrapReady = 8'b0101_1001;
        rst_n = 1'b1;
        vin   = 1'b0;
        din   = '0;
        rin   = 1'b0;
        flush = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 checkOutput("ready_o right after reset release", 32'(gInst[0].bus.ready_o), 32'd1);

        // Fill then drain with the downstream stalled first.
        applyStimulus(1'b1, 16'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hA2, 1'b0, 1'b0);
        #1;
        checkOutput("fill count_o", 32'(gInst[0].bus.count_o), 32'd2);
        checkOutput("fill ready_o", 32'(gInst[0].bus.ready_o), 32'd0);
        checkOutput("fill head data_o", 32'(gInst[0].bus.data_o), 32'hA1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        drain(3);

        // Streaming with incrementing data.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, DataWidth'(16'h100 + i), 1'b1, 1'b0);
        drain(3);

        // Wrap-around with a fixed downstream ready pattern.
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, DataWidth'(16'h200 + i), wrapReady[i], 1'b0);
        drain(4);

        // Flush with two entries held and a push attempt in the same cycle.
        applyStimulus(1'b1, 16'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h22, 1'b0, 1'b0);
        vin = 1'b1; din = 16'hEE; rin = 1'b1; flush = 1'b1;
        #2;
        checkOutput("flush-cycle ready_o", 32'(gInst[0].bus.ready_o), 32'd0);
        checkOutput("flush-cycle valid_o", 32'(gInst[0].bus.valid_o), 32'd0);
        @(posedge clk); #1;
        vin = 1'b1; din = 16'h55; rin = 1'b0; flush = 1'b0;
        #1;
        checkOutput("post-flush count_o", 32'(gInst[0].bus.count_o), 32'd0);
        checkOutput("post-flush valid_o", 32'(gInst[0].bus.valid_o), 32'd0);
        checkOutput("post-flush ready_o", 32'(gInst[0].bus.ready_o), 32'd1);
        @(posedge clk); #1;
        drain(3);

        // Fall-through: same-cycle bypass, then storage when the consumer stalls.
        vin = 1'b1; din = 16'h3C; rin = 1'b1; flush = 1'b0;
        #2;
        checkOutput("ft bypass valid_o", 32'(gInst[2].bus.valid_o), 32'd1);
        checkOutput("ft bypass data_o", 32'(gInst[2].bus.data_o), 32'h3C);
        checkOutput("ft bypass count_o", 32'(gInst[2].bus.count_o), 32'd0);
        @(posedge clk); #1;
        drain(3);
        applyStimulus(1'b1, 16'h3C, 1'b0, 1'b0);
        #1 checkOutput("ft stalled count_o", 32'(gInst[2].bus.count_o), 32'd1);
        drain(3);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, DataWidth'($urandom), ($urandom % 3) != 0,
                          ($urandom % 32) == 0);
        end
        drain(4);

        // Asynchronous reset in the middle of a cycle with two entries held.
        applyStimulus(1'b1, 16'h61, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h62, 1'b0, 1'b0);
        vin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset valid_o", 32'(gInst[0].bus.valid_o), 32'd0);
        checkOutput("async reset ready_o", 32'(gInst[0].bus.ready_o), 32'd0);
        checkOutput("async reset count_o", 32'(gInst[0].bus.count_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; vin = 1'b1; din = 16'h77; rin = 1'b0;
        #1 checkOutput("first push ready_o after reset", 32'(gInst[0].bus.ready_o), 32'd1);
        @(posedge clk); #1;
        #1 checkOutput("first push count_o after reset", 32'(gInst[0].bus.count_o), 32'd1);
        drain(4);

        for (int i = 0; i < 100; i++) begin
            applyStimulus(($urandom % 2) != 0, DataWidth'($urandom), ($urandom % 2) != 0, 1'b0);
        end
        drain(4);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised ready/valid pipeline stage buffer: a generalisation of the single-entry fetch/decode stage register to a configurable payload width and depth. It has an optional fall-through mode and a synchronous flush that discards all buffered entries. It sits between any two CPU pipeline stages, e.g. fetch→decode carrying {PC, instruction}. Occupancy is exported for hazard and performance logic.

## Interface
- DataWidth, default 96: payload width in bits (e.g. 64-bit PC + 32-bit instruction).
- Depth, default 2: number of entries; legal range 1..16, not required to be a power of two.
- FallThrough, default 0: 1 = when empty, input passes combinationally to the output in the same cycle.
- ClearDataOnReset, default 0: 1 = storage array is zeroed by reset; 0 = storage is not reset.
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_ni  input  1  reset, asynchronous and active-low.
- flush_i  input  1  synchronous flush; discards all entries and any input that cycle.
- valid_i  input  1  upstream presents valid data_i.
- data_i  input  DataWidth  payload in.
- ready_o  output  1  buffer can accept data_i this cycle.
- valid_o  output  1  data_o holds a valid entry.
- data_o  output  DataWidth  head-of-queue payload.
- ready_i  input  1  downstream accepts data_o this cycle.
- count_o  output  $clog2(Depth+1)  current number of stored entries.

## Operation
- Storage is a circular buffer with read pointer rd_q, write pointer wr_q and count_q.
- Pointers advance by 1 and wrap from Depth-1 to 0 explicitly; there is no power-of-two masking.
- Push occurs when valid_i & ready_o. Pop occurs when valid_o & ready_i.
- ready_o = (count_q < Depth) & ~flush_i & reset_ni.
- There is no combinational path from ready_i to ready_o. When the buffer is full, ready_o = 0 even if ready_i = 1.
- Registered mode (FallThrough=0):
  - valid_o = (count_q != 0) & ~flush_i.
  - data_o = mem[rd_q].
- Fall-through mode (FallThrough=1):
  - When count_q = 0: valid_o = valid_i & ~flush_i and data_o = data_i.
  - In that case, if ready_i = 1 the item is consumed directly, with no write and no count change.
  - If ready_i = 0, the item is written to mem[wr_q].
  - When count_q > 0, behaviour is the same as registered mode.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; write at wr_q and read at rd_q, with both pointers advancing.
- Flush: at the clock edge with flush_i = 1, count_q, rd_q and wr_q all go to 0.
  - valid_o and ready_o are forced to 0 during the flush cycle, so no handshake can complete.
  - Stored data is left stale.
- Reset: asynchronous on the falling edge of reset_ni.
  - count_q, rd_q and wr_q go to 0; mem is zeroed only if ClearDataOnReset.
  - While reset is asserted: valid_o = 0, ready_o = 0, count_o = 0.
  - data_o is undefined unless ClearDataOnReset (then 0).
- count_o = count_q (the registered value).
- Overflow and underflow are impossible by construction. An assertion fires if a push occurs at count_q = Depth or a pop at count_q = 0.

## Timing
- Registered mode latency: 1 cycle from push to valid_o.
- Fall-through mode latency: 0 cycles when empty, 1 cycle otherwise.
- Sustained throughput is 1 item/cycle for Depth ≥ 2.
- Depth = 1, registered mode: behaves as the original single-entry stage. When full, ready_o = 0, so back-to-back throughput is 1 item per 2 cycles.
- After reset deassertion, the first push is accepted in the first cycle (ready_o = 1 combinationally once reset_ni = 1).
- Flush takes effect in 1 cycle: the cycle after flush_i has count_o = 0, valid_o = 0 (fall-through mode: valid_o = valid_i) and ready_o = 1.
- Reset mid-operation: all entries are lost immediately and asynchronously. No partial handshake is completed.
- data_o remains stable while valid_o = 1 and ready_i = 0; ordering is strict FIFO.

## Test plan
- Reset then fill, Depth=2, registered: push 0xA1 then 0xA2 with ready_i=0 → count_o 1 then 2, ready_o=0 after 2 pushes. With ready_i=1 → data_o 0xA1 then 0xA2, then count_o=0.
- Streaming: valid_i=ready_i=1 for 20 cycles with incrementing data → output is identical in order, 1 cycle behind, count_o constant at 1.
- Wrap-around, Depth=3: 7 pushes interleaved with random pops (ready_i pattern 1,0,0,1,1,0,1) → output order preserved across pointer wrap; count_o never exceeds 3.
- Flush with 2 entries and valid_i=1 in the same cycle → no handshake that cycle; next cycle count_o=0, valid_o=0. Only the next pushed value (0x55) is output.
- FallThrough=1, empty, valid_i=1, data_i=0x3C, ready_i=1 → valid_o=1 and data_o=0x3C the same cycle, count_o remains 0. Same stimulus with ready_i=0 → count_o=1 next cycle.
- Asynchronous reset asserted mid-cycle with count_o=2 → valid_o, ready_o and count_o go to 0 before the next clock edge. After release, the first push is accepted immediately.
